// File: rtl/s_axi_stream.sv
// s_axi_stream: AXI4-Stream slave capturing one frame into a random-access buffer,
// reporting length, running sum and overflow until the consumer releases it.
module s_axi_stream #(
    parameter int DWIDTH  = 32,
    parameter int BUFSIZE = 8
) (
    input  logic                clk,
    input  logic                xrst,
    input  logic                tvalid,
    input  logic [DWIDTH-1:0]   tdata,
    input  logic [DWIDTH/8-1:0] tstrb,
    input  logic                tlast,
    output logic                tready,
    input  logic [BUFSIZE-1:0]  rd_addr,
    output logic [DWIDTH-1:0]   rd_data,
    output logic                frame_done,
    output logic [BUFSIZE:0]    frame_len,
    output logic [DWIDTH-1:0]   frame_sum,
    output logic                overflow,
    input  logic                release_i
);
    localparam int WORDS = 2 ** BUFSIZE;
    localparam logic [BUFSIZE:0]   LEN_FULL = (BUFSIZE+1)'(WORDS);
    localparam logic [BUFSIZE:0]   LEN_ONE  = (BUFSIZE+1)'(1);
    localparam logic [BUFSIZE-1:0] PTR_ONE  = BUFSIZE'(1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [BUFSIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [BUFSIZE:0]   len_q, len_d;
    logic [DWIDTH-1:0]  sum_q, sum_d;
    logic               ovf_q, ovf_d;
    logic [DWIDTH-1:0]  rd_data_q;
    logic [DWIDTH-1:0]  masked;
    logic               we;
    logic [DWIDTH-1:0]  mem [WORDS];

    genvar b;
    generate
        for (b = 0; b < DWIDTH/8; b++) begin : g_mask
            assign masked[8*b +: 8] = tstrb[b] ? tdata[8*b +: 8] : 8'h00;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        len_d    = len_q;
        sum_d    = sum_q;
        ovf_d    = ovf_q;
        we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d  = S_RECV;
                wr_ptr_d = '0;
                len_d    = '0;
                sum_d    = '0;
                ovf_d    = 1'b0;
            end
            S_RECV: if (tvalid) begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                sum_d    = sum_q + masked;
                // tlast wins over overflow so an exactly-full frame is not flagged
                if (tlast) begin
                    state_d = S_DONE;
                    len_d   = {1'b0, wr_ptr_q} + LEN_ONE;
                end else if (wr_ptr_q == '1) begin
                    state_d = S_DRAIN;
                    len_d   = LEN_FULL;
                    ovf_d   = 1'b1;
                end
            end
            S_DRAIN: state_d = (tvalid && tlast) ? S_DONE : S_DRAIN;
            S_DONE: if (release_i) begin
                state_d  = S_IDLE;
                wr_ptr_d = '0;
                len_d    = '0;
                sum_d    = '0;
                ovf_d    = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            len_q     <= '0;
            sum_q     <= '0;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            ovf_q     <= ovf_d;
            rd_data_q <= mem[rd_addr];
        end
    end

    // Buffer is never cleared; stale words past frame_len are expected
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr_q] <= masked;
    end

    assign tready     = (state_q == S_RECV) || (state_q == S_DRAIN);
    assign frame_done = (state_q == S_DONE);
    assign frame_len  = len_q;
    assign frame_sum  = sum_q;
    assign overflow   = ovf_q;
    assign rd_data    = rd_data_q;
endmodule

// File: tb/tb_s_axi_stream.sv
// tb_s_axi_stream: directed self-checking bench for s_axi_stream with an 8-word buffer.
module tb_s_axi_stream;
    localparam int DW = 32;
    localparam int BS = 3;

    logic          clk = 1'b0;
    logic          xrst = 1'b0;
    logic          tvalid = 1'b0;
    logic [DW-1:0] tdata = '0;
    logic [3:0]    tstrb = '0;
    logic          tlast = 1'b0;
    logic          tready;
    logic [BS-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          frame_done;
    logic [BS:0]   frame_len;
    logic [DW-1:0] frame_sum;
    logic          overflow;
    logic          release_i = 1'b0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    s_axi_stream #(.DWIDTH(DW), .BUFSIZE(BS)) dut (
        .clk(clk), .xrst(xrst), .tvalid(tvalid), .tdata(tdata), .tstrb(tstrb),
        .tlast(tlast), .tready(tready), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_done(frame_done), .frame_len(frame_len), .frame_sum(frame_sum),
        .overflow(overflow), .release_i(release_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive at negedge; tready is stable there, so the next posedge accepts when it is 1
    task automatic send(input logic [DW-1:0] d, input logic [3:0] s, input logic l, input int gap);
        int n;
        n = 0;
        repeat (gap) @(negedge clk);
        tvalid = 1'b1; tdata = d; tstrb = s; tlast = l;
        while (!tready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) check("tready_timeout", tready, 1);
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic read(input int a, input logic [DW-1:0] exp);
        rd_addr = BS'(a);
        @(negedge clk);
        check($sformatf("rd_data[%0d]", a), rd_data, exp);
    endtask

    task automatic do_release();
        release_i = 1'b1;
        @(negedge clk);
        release_i = 1'b0;
        check("rel_done", frame_done, 0);
        check("rel_tready_turnaround", tready, 0);
        @(negedge clk);
        check("rel_tready", tready, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_tready", tready, 0);
        check("rst_done", frame_done, 0);
        check("rst_len", frame_len, 0);
        check("rst_sum", frame_sum, 0);
        check("rst_ovf", overflow, 0);
        check("rst_rd_data", rd_data, 0);
        xrst = 1'b1;

        for (int i = 1; i <= 5; i++) send(DW'(i), 4'hF, i == 5, 0);
        check("basic_done", frame_done, 1);
        check("basic_len", frame_len, 5);
        check("basic_sum", frame_sum, 15);
        check("basic_ovf", overflow, 0);
        check("basic_tready", tready, 0);
        for (int i = 0; i < 5; i++) read(i, DW'(i + 1));
        do_release();

        send(32'hAABBCCDD, 4'b0101, 1'b1, $urandom_range(0, 3));
        check("mask_done", frame_done, 1);
        check("mask_len", frame_len, 1);
        check("mask_sum", frame_sum, 32'h00BB00DD);
        read(0, 32'h00BB00DD);
        read(1, 2);
        do_release();

        for (int i = 0; i < 8; i++) send(DW'(10 + i), 4'hF, i == 7, $urandom_range(0, 2));
        check("full_len", frame_len, 8);
        check("full_ovf", overflow, 0);
        check("full_sum", frame_sum, 108);
        check("full_done", frame_done, 1);
        read(7, 17);
        do_release();

        for (int i = 1; i <= 11; i++) begin
            if (i == 11) check("ovf_tready_last", tready, 1);
            send(1, 4'hF, i == 11, 0);
            if (i == 9) check("ovf_flag_drain", overflow, 1);
        end
        check("ovf_flag", overflow, 1);
        check("ovf_len", frame_len, 8);
        check("ovf_sum", frame_sum, 8);
        check("ovf_done", frame_done, 1);
        do_release();

        send(5, 4'hF, 1'b0, 0);
        release_i = 1'b1;
        @(negedge clk);
        release_i = 1'b0;
        check("recv_rel_tready", tready, 1);
        check("recv_rel_done", frame_done, 0);
        send(6, 4'hF, 1'b1, 0);
        check("b2b_len", frame_len, 2);
        check("b2b_sum", frame_sum, 11);
        check("b2b_done", frame_done, 1);
        do_release();

        for (int i = 0; i < 3; i++) send(DW'(20 + i), 4'hF, 1'b0, 0);
        check("pre_rst_sum", frame_sum, 63);
        #2 xrst = 1'b0;
        #1;
        check("mid_rst_tready", tready, 0);
        check("mid_rst_done", frame_done, 0);
        check("mid_rst_len", frame_len, 0);
        check("mid_rst_sum", frame_sum, 0);
        check("mid_rst_ovf", overflow, 0);
        @(negedge clk);
        xrst = 1'b1;
        send(7, 4'hF, 1'b0, 0);
        send(8, 4'hF, 1'b1, 0);
        check("post_rst_len", frame_len, 2);
        check("post_rst_sum", frame_sum, 15);
        check("post_rst_done", frame_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
